// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared types and constants for the stopwatch controller.
//   sw_state_t : controller states IDLE, RUN, PAUSE, ADJUST
//   SW_MAX_SEC : terminal value of the seconds counter
//   SW_MAX_MIN : terminal value of the minutes counter
//   SW_CNT_W   : width of both counters
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } sw_state_t;

  localparam int SW_MAX_SEC = 59;
  localparam int SW_MAX_MIN = 59;
  localparam int SW_CNT_W   = 6;

endpackage

// File: rtl/sw_mod_counter.sv
// sw_mod_counter -- modulo counter 0..MAX with synchronous clear.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   i_inc    : increment enable
//   i_clr    : synchronous clear, wins over i_inc
//   o_q      : current count (registered)
//   o_carry  : high in the cycle an increment wraps MAX -> 0
// The counter does no chaining itself; the owner decides whether the
// carry is used, so a field can be wrapped without touching its neighbour.
module sw_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int W   = SW_CNT_W,
  parameter int MAX = SW_MAX_SEC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q,
  output logic         o_carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_q;

  // Out-of-range values reload 0 on the next increment (>= rather than ==).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= (r_q >= MAX_V) ? '0 : r_q + 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_inc & ~i_clr & (r_q == MAX_V);

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- run/pause/clear/adjust sequencer for the stopwatch.
// Optional feature macro: SW_LAP_EN (lap display hold).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   tick_1hz        : count-enable pulse
//   tick_blink      : blink phase toggle pulse (used in ADJUST)
//   btn_startstop   : run/pause toggle pulse
//   btn_clear       : zero counters pulse
//   adj_mode        : level, adjust mode request
//   adj_sel         : level, field to adjust (0 seconds, 1 minutes)
//   adj_inc         : increment selected field pulse
//   lap             : level, freeze display (SW_LAP_EN only)
//   minutes/seconds : displayed count
//   running         : 1 while in RUN
//   blank_min/sec   : digit blanking for the adjust blink
//   rollover        : one-cycle pulse on MAX:MAX -> 00:00 while running
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_SEC = SW_MAX_SEC,
  parameter int MAX_MIN = SW_MAX_MIN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_1hz,
  input  logic                tick_blink,
  input  logic                btn_startstop,
  input  logic                btn_clear,
  input  logic                adj_mode,
  input  logic                adj_sel,
  input  logic                adj_inc,
  input  logic                lap,
  output logic [SW_CNT_W-1:0] minutes,
  output logic [SW_CNT_W-1:0] seconds,
  output logic                running,
  output logic                blank_min,
  output logic                blank_sec,
  output logic                rollover
);

  sw_state_t r_state, w_state_next;
  logic r_phase, w_phase_next;
  logic r_running, r_blank_min, r_blank_sec, r_rollover, w_rollover_next;
  logic w_sec_inc, w_min_inc, w_cnt_clr;
  logic w_sec_carry, w_min_carry;
  logic [SW_CNT_W-1:0] w_sec_live, w_min_live;

  sw_mod_counter #(.W(SW_CNT_W), .MAX(MAX_SEC)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_sec_inc),
    .i_clr  (w_cnt_clr),
    .o_q    (w_sec_live),
    .o_carry(w_sec_carry)
  );

  sw_mod_counter #(.W(SW_CNT_W), .MAX(MAX_MIN)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_min_inc),
    .i_clr  (w_cnt_clr),
    .o_q    (w_min_live),
    .o_carry(w_min_carry)
  );

  // Priority: clear, adj_mode, startstop, then tick/adj_inc.
  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_sec_inc       = 1'b0;
    w_min_inc       = 1'b0;
    w_cnt_clr       = 1'b0;
    w_rollover_next = 1'b0;
    if (btn_clear) begin
      w_cnt_clr    = 1'b1;
      w_phase_next = 1'b0;
      w_state_next = adj_mode ? ADJUST : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (adj_mode)           w_state_next = ADJUST;
          else if (btn_startstop) w_state_next = RUN;
        end
        RUN: begin
          if (adj_mode) begin
            w_state_next = ADJUST;  // tick in this cycle is dropped
          end else begin
            if (tick_1hz) begin
              w_sec_inc       = 1'b1;
              w_min_inc       = w_sec_carry;  // chaining only while running
              w_rollover_next = w_sec_carry & w_min_carry;
            end
            if (btn_startstop) w_state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (adj_mode)           w_state_next = ADJUST;
          else if (btn_startstop) w_state_next = RUN;
        end
        default: begin  // ADJUST
          if (!adj_mode) begin
            w_phase_next = 1'b0;
            w_state_next = ((w_sec_live == '0) && (w_min_live == '0)) ? IDLE : PAUSE;
          end else begin
            if (adj_inc) begin
              w_sec_inc = ~adj_sel;
              w_min_inc = adj_sel;
            end
            if (tick_blink) w_phase_next = ~r_phase;
          end
        end
      endcase
    end
  end

  // Phase is only ever non-zero in ADJUST, so blanking follows it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= 1'b0;
      r_running   <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
      r_rollover  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_running   <= (w_state_next == RUN);
      r_blank_min <= w_phase_next & adj_sel;
      r_blank_sec <= w_phase_next & ~adj_sel;
      r_rollover  <= w_rollover_next;
    end
  end

  assign running   = r_running;
  assign blank_min = r_blank_min;
  assign blank_sec = r_blank_sec;
  assign rollover  = r_rollover;

`ifdef SW_LAP_EN
  logic r_lap_prev, r_hold, w_hold_next;
  logic [SW_CNT_W-1:0] r_hold_sec, r_hold_min;

  // Hold starts on a rising lap edge (capturing the count shown at that
  // edge) and lasts while lap stays high; clear or ADJUST drop it.
  assign w_hold_next = lap & ~btn_clear & (w_state_next != ADJUST) &
                       (r_hold | ~r_lap_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_prev <= 1'b0;
      r_hold     <= 1'b0;
      r_hold_sec <= '0;
      r_hold_min <= '0;
    end else begin
      r_lap_prev <= lap;
      r_hold     <= w_hold_next;
      if (w_hold_next && !r_hold) begin
        r_hold_sec <= w_sec_live;
        r_hold_min <= w_min_live;
      end
    end
  end

  assign minutes = r_hold ? r_hold_min : w_min_live;
  assign seconds = r_hold ? r_hold_sec : w_sec_live;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;
  assign minutes = w_min_live;
  assign seconds = w_sec_live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl -- directed plus randomized bench for stopwatch_ctrl.
// The reference model keeps elapsed time as plain integers and a mode code;
// the compare process checks every output one time unit after each clock edge.
module tb_stopwatch_ctrl;

  localparam int MS = 59;
  localparam int MM = 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ADJ = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0, tick_blink = 1'b0, btn_startstop = 1'b0, btn_clear = 1'b0;
  logic adj_mode = 1'b0, adj_sel = 1'b0, adj_inc = 1'b0, lap = 1'b0;
  logic [5:0] minutes, seconds;
  logic running, blank_min, blank_sec, rollover;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .tick_blink   (tick_blink),
    .btn_startstop(btn_startstop),
    .btn_clear    (btn_clear),
    .adj_mode     (adj_mode),
    .adj_sel      (adj_sel),
    .adj_inc      (adj_inc),
    .lap          (lap),
    .minutes      (minutes),
    .seconds      (seconds),
    .running      (running),
    .blank_min    (blank_min),
    .blank_sec    (blank_sec),
    .rollover     (rollover)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int m_sec = 0, m_min = 0, m_mode = M_IDLE, m_phase = 0, m_roll = 0;
  int m_bsec = 0, m_bmin = 0;
  int m_hold = 0, m_hsec = 0, m_hmin = 0, m_lapp = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_mode = M_IDLE; m_phase = 0; m_roll = 0;
    m_bsec = 0; m_bmin = 0; m_hold = 0; m_hsec = 0; m_hmin = 0; m_lapp = 0;
  endtask

  task automatic model_step();
    int total;
`ifdef SW_LAP_EN
    int psec, pmin;
    psec = m_sec;
    pmin = m_min;
`endif
    m_roll = 0;
    if (btn_clear) begin
      m_sec = 0; m_min = 0; m_phase = 0;
      m_mode = adj_mode ? M_ADJ : M_IDLE;
    end else if (m_mode == M_ADJ) begin
      if (!adj_mode) begin
        m_phase = 0;
        m_mode = (m_sec == 0 && m_min == 0) ? M_IDLE : M_PAUSE;
      end else begin
        if (adj_inc) begin
          if (adj_sel) m_min = (m_min + 1) % (MM + 1);
          else         m_sec = (m_sec + 1) % (MS + 1);
        end
        if (tick_blink) m_phase = 1 - m_phase;
      end
    end else if (adj_mode) begin
      m_mode = M_ADJ;
    end else begin
      if (m_mode == M_RUN && tick_1hz) begin
        total = m_min * (MS + 1) + m_sec + 1;
        if (total == (MM + 1) * (MS + 1)) begin
          total = 0;
          m_roll = 1;
        end
        m_sec = total % (MS + 1);
        m_min = total / (MS + 1);
      end
      if (btn_startstop) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
    m_bsec = (m_mode == M_ADJ && m_phase == 1 && !adj_sel) ? 1 : 0;
    m_bmin = (m_mode == M_ADJ && m_phase == 1 && adj_sel) ? 1 : 0;
`ifdef SW_LAP_EN
    if (btn_clear || !lap || m_mode == M_ADJ) begin
      m_hold = 0;
    end else if (m_lapp == 0 && m_hold == 0) begin
      m_hold = 1; m_hsec = psec; m_hmin = pmin;
    end
    m_lapp = lap ? 1 : 0;
`endif
  endtask

  // Compare process: every cycle, one time unit after the active edge.
  always @(posedge clk) begin
    #1;
    chk("minutes", minutes, (m_hold != 0) ? m_hmin : m_min);
    chk("seconds", seconds, (m_hold != 0) ? m_hsec : m_sec);
    chk("running", running, (m_mode == M_RUN) ? 1 : 0);
    chk("blank_sec", blank_sec, m_bsec);
    chk("blank_min", blank_min, m_bmin);
    chk("rollover", rollover, m_roll);
  end

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    btn_clear = 1'b0; btn_startstop = 1'b0; tick_1hz = 1'b0;
    adj_inc = 1'b0; tick_blink = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      step();
    end
  endtask

  task automatic incs(input int n);
    repeat (n) begin
      adj_inc = 1'b1;
      step();
    end
  endtask

  initial begin
    // Reset
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_min", minutes, 0);
    chk("reset_sec", seconds, 0);
    chk("reset_running", running, 0);
    chk("reset_rollover", rollover, 0);
    rst_n = 1'b1;
    step();

    // Start and 61 ticks -> 01:01 running
    btn_startstop = 1'b1; step();
    ticks(61);
    chk("t61_min", minutes, 1);
    chk("t61_sec", seconds, 1);
    chk("t61_running", running, 1);

    // Startstop and tick together: tick counted, then paused
    btn_startstop = 1'b1; tick_1hz = 1'b1; step();
    chk("ss_tick_sec", seconds, 2);
    chk("ss_tick_running", running, 0);
    ticks(3);
    chk("pause_hold_sec", seconds, 2);

    // Clear into ADJUST, preload 59:59, leave, start, one tick -> rollover
    btn_clear = 1'b1; adj_mode = 1'b1; step();
    adj_sel = 1'b0; incs(59);
    adj_sel = 1'b1; incs(59);
    chk("preload_min", minutes, 59);
    chk("preload_sec", seconds, 59);
    adj_mode = 1'b0; step();
    btn_startstop = 1'b1; step();
    chk("preload_running", running, 1);
    ticks(1);
    chk("roll_min", minutes, 0);
    chk("roll_sec", seconds, 0);
    chk("roll_pulse", rollover, 1);
    step();
    chk("roll_pulse_end", rollover, 0);

    // ADJUST wrap without carry and blink behaviour
    adj_mode = 1'b1; step();
    adj_sel = 1'b1; incs(1);
    adj_sel = 1'b0; incs(59);
    chk("adj_pre_sec", seconds, 59);
    incs(1);
    chk("adj_wrap_sec", seconds, 0);
    chk("adj_wrap_min", minutes, 1);
    tick_blink = 1'b1; step();
    chk("blink_sec", blank_sec, 1);
    chk("blink_min", blank_min, 0);
    adj_mode = 1'b0; step();
    chk("exit_blank_sec", blank_sec, 0);
    chk("exit_running", running, 0);
    btn_startstop = 1'b1; step();
    chk("pause_to_run", running, 1);

    // Run to 03:12 then clear+adj_mode together
    ticks(132);
    chk("run312_min", minutes, 3);
    chk("run312_sec", seconds, 12);
    btn_clear = 1'b1; adj_mode = 1'b1; step();
    chk("clradj_min", minutes, 0);
    chk("clradj_sec", seconds, 0);
    chk("clradj_running", running, 0);
    adj_sel = 1'b0; tick_blink = 1'b1; step();
    chk("clradj_blink", blank_sec, 1);
    adj_mode = 1'b0; step();

`ifdef SW_LAP_EN
    // Lap hold
    btn_clear = 1'b1; step();
    btn_startstop = 1'b1; step();
    ticks(10);
    lap = 1'b1; step();
    ticks(5);
    chk("lap_hold_min", minutes, 0);
    chk("lap_hold_sec", seconds, 10);
    lap = 1'b0; step();
    chk("lap_release_sec", seconds, 15);
`endif

    // Asynchronous reset in the middle of RUN
    btn_clear = 1'b1; step();
    btn_startstop = 1'b1; step();
    ticks(7);
    chk("prereset_sec", seconds, 7);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_sec", seconds, 0);
    chk("async_rst_running", running, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) adj_mode = ~adj_mode;
      if ($urandom_range(0, 19) == 0) adj_sel = ~adj_sel;
      if ($urandom_range(0, 24) == 0) lap = ~lap;
      btn_clear     = ($urandom_range(0, 79) == 0);
      btn_startstop = ($urandom_range(0, 11) == 0);
      tick_1hz      = ($urandom_range(0, 2) == 0);
      adj_inc       = ($urandom_range(0, 3) == 0);
      tick_blink    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
